// File: rtl/banner_pkg.sv
// Shared constants and helpers for the rotating-banner datapath and its VGA timing core.
package banner_pkg;

  // Display geometry shared with the VGA timing core (640x480 visible area).
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  // Character scale codes: code n means glyphs drawn at (n+1)x.
  localparam logic [1:0] SCALE_X1    = 2'd0;
  localparam logic [1:0] SCALE_X4    = 2'd3;
  localparam logic [1:0] SCALE_RESET = SCALE_X1;

  // Scroll speed codes, mapped to pixel steps by speed_step().
  localparam logic [1:0] SPEED_STOP  = 2'd0;
  localparam logic [1:0] SPEED_SLOW  = 2'd1;
  localparam logic [1:0] SPEED_MED   = 2'd2;
  localparam logic [1:0] SPEED_FAST  = 2'd3;
  localparam logic [1:0] SPEED_RESET = SPEED_SLOW;

  // Both settings share the same 0..3 code range.
  localparam logic [1:0] CODE_MIN = 2'd0;
  localparam logic [1:0] CODE_MAX = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StPress,
    StHold
  } db_state_e;

  // Pixels advanced per frame for a speed code: 0, 1, 2, 4.
  function automatic logic [2:0] speed_step(input logic [1:0] speed);
    logic [2:0] step;
    case (speed)
      SPEED_STOP: step = 3'd0;
      SPEED_SLOW: step = 3'd1;
      SPEED_MED:  step = 3'd2;
      default:    step = 3'd4;
    endcase
    return step;
  endfunction

  // Saturating up/down on a 2-bit code; simultaneous up and down cancel.
  function automatic logic [1:0] bump_code(input logic [1:0] cur, input logic up,
                                           input logic dn);
    logic [1:0] res;
    res = cur;
    if (up && !dn && cur != CODE_MAX) begin
      res = cur + 2'd1;
    end else if (dn && !up && cur != CODE_MIN) begin
      res = cur - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser, press-detect FSM, single-cycle press pulse.
module key_debounce
  import banner_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  db_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // Synchronise the raw button; idle level is high (released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
    end
  end

  // Next state: a press needs DB_CYCLES consecutive low samples in StArm.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!sync2_q) begin
          state_d = StArm;
          cnt_d   = '0;
        end
      end
      StArm: begin
        if (sync2_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StPress;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPress: state_d = StHold;
      StHold: begin
        if (sync2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    press_d = (state_d == StPress);
  end

  // FSM state, counter and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/banner_scroll_ctrl.sv
// Banner sequencing: debounced settings, per-frame scroll offset, tear-free commit at vblank.
module banner_scroll_ctrl
  import banner_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = 250_000,
  parameter int unsigned BANNER_CHARS = 32,
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned V_DISP       = V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key,
  input  logic [11:0] pixel_x,
  input  logic [11:0] pixel_y,
  output logic        frame_tick,
  output logic [1:0]  char_scale,
  output logic [1:0]  scroll_speed,
  output logic [11:0] scroll_offset
);

  localparam int unsigned BannerPx = BANNER_CHARS * CHAR_W;

  // The widest banner (scale x4) must still be addressable by a 12-bit offset.
  if (BannerPx * 4 > 4095) begin : g_width_check
    $error("banner_scroll_ctrl: BANNER_CHARS*CHAR_W*4 exceeds 12-bit offset range");
  end

  logic [3:0]  press;
  logic [1:0]  pend_scale_q, pend_scale_d;
  logic [1:0]  pend_speed_q, pend_speed_d;
  logic        frame_tick_q, frame_tick_d;
  logic [1:0]  char_scale_q, char_scale_d;
  logic [1:0]  scroll_speed_q, scroll_speed_d;
  logic [11:0] scroll_offset_q, scroll_offset_d;
  logic [11:0] wrap_len;
  logic [12:0] nxt;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_ni (key[i]),
      .press_o(press[i])
    );
  end

  // Pending settings follow press pulses; tick detection on the first vblank pixel.
  always_comb begin
    pend_scale_d = bump_code(pend_scale_q, press[0], press[1]);
    pend_speed_d = bump_code(pend_speed_q, press[2], press[3]);
    frame_tick_d = (pixel_y == 12'(V_DISP)) && (pixel_x == 12'd0);
  end

  // Commit uses the same-cycle pending values so a press on the tick is not a frame late.
  always_comb begin
    char_scale_d    = char_scale_q;
    scroll_speed_d  = scroll_speed_q;
    scroll_offset_d = scroll_offset_q;
    wrap_len        = 12'(BannerPx) * (12'(pend_scale_d) + 12'd1);
    nxt             = {1'b0, scroll_offset_q} + 13'(speed_step(pend_speed_d));
    if (frame_tick_q) begin
      char_scale_d   = pend_scale_d;
      scroll_speed_d = pend_speed_d;
      if (pend_scale_d != char_scale_q) begin
        scroll_offset_d = 12'd0;
      end else if (nxt >= {1'b0, wrap_len}) begin
        scroll_offset_d = 12'(nxt - {1'b0, wrap_len});
      end else begin
        scroll_offset_d = nxt[11:0];
      end
    end
  end

  // Pending, tick and committed registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_scale_q    <= SCALE_RESET;
      pend_speed_q    <= SPEED_RESET;
      frame_tick_q    <= 1'b0;
      char_scale_q    <= SCALE_RESET;
      scroll_speed_q  <= SPEED_RESET;
      scroll_offset_q <= 12'd0;
    end else begin
      pend_scale_q    <= pend_scale_d;
      pend_speed_q    <= pend_speed_d;
      frame_tick_q    <= frame_tick_d;
      char_scale_q    <= char_scale_d;
      scroll_speed_q  <= scroll_speed_d;
      scroll_offset_q <= scroll_offset_d;
    end
  end

  assign frame_tick    = frame_tick_q;
  assign char_scale    = char_scale_q;
  assign scroll_speed  = scroll_speed_q;
  assign scroll_offset = scroll_offset_q;

endmodule
